// File: rtl/stopwatch_ctrl_if.sv
// rtl/stopwatch_ctrl_if.sv - command/tick inputs and display outputs of the stopwatch; STOPWATCH_OVFL_EN adds ovfl
interface stopwatch_ctrl_if;
    logic       tick;
    logic       start_stop;
    logic       lap;
    logic       clr;
    logic [3:0] disp_s1;
    logic [2:0] disp_s10;
    logic [3:0] disp_m1;
    logic [2:0] disp_m10;
    logic       running;
    logic       lap_hold;
    logic       min_evt;
`ifdef STOPWATCH_OVFL_EN
    logic       ovfl;

    modport master (
        output tick, start_stop, lap, clr,
        input  disp_s1, disp_s10, disp_m1, disp_m10, running, lap_hold, min_evt, ovfl
    );
    modport slave (
        input  tick, start_stop, lap, clr,
        output disp_s1, disp_s10, disp_m1, disp_m10, running, lap_hold, min_evt, ovfl
    );
`else
    modport master (
        output tick, start_stop, lap, clr,
        input  disp_s1, disp_s10, disp_m1, disp_m10, running, lap_hold, min_evt
    );
    modport slave (
        input  tick, start_stop, lap, clr,
        output disp_s1, disp_s10, disp_m1, disp_m10, running, lap_hold, min_evt
    );
`endif
endinterface

// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - MM:SS stopwatch sequencer with lap freeze; STOPWATCH_OVFL_EN adds a sticky ovfl flag
module stopwatch_ctrl #(
    parameter bit SAT_MODE = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    stopwatch_ctrl_if.slave  sw
);
    typedef enum logic [1:0] {IDLE, RUN, LAP, PAUSE} state_t;

    state_t     state_q;
    logic [3:0] s1_q, m1_q, s1_d, m1_d;
    logic [2:0] s10_q, m10_q, s10_d, m10_d;
    logic [3:0] l_s1_q, l_m1_q;
    logic [2:0] l_s10_q, l_m10_q;
    logic       min_evt_q;

    logic cmd_clr, cmd_ss, cmd_lap;
    logic at_max, counting, en0, c1, c2, c3, c4;
    logic do_clear, lap_take;

    // Strict priority: a higher command swallows lower ones even if it is ignored in this state.
    assign cmd_clr = sw.clr;
    assign cmd_ss  = ~sw.clr & sw.start_stop;
    assign cmd_lap = ~sw.clr & ~sw.start_stop & sw.lap;

    assign at_max   = (s1_q == 4'd9) && (s10_q == 3'd5) && (m1_q == 4'd9) && (m10_q == 3'd5);
    assign counting = (state_q == RUN) || (state_q == LAP);
    assign en0      = sw.tick & counting & ~(SAT_MODE & at_max);

    assign c1 = en0 & (s1_q  == 4'd9);
    assign c2 = c1  & (s10_q == 3'd5);
    assign c3 = c2  & (m1_q  == 4'd9);
    assign c4 = c3  & (m10_q == 3'd5);

    assign s1_d  = en0 ? ((s1_q  == 4'd9) ? 4'd0 : s1_q  + 4'd1) : s1_q;
    assign s10_d = c1  ? ((s10_q == 3'd5) ? 3'd0 : s10_q + 3'd1) : s10_q;
    assign m1_d  = c2  ? ((m1_q  == 4'd9) ? 4'd0 : m1_q  + 4'd1) : m1_q;
    assign m10_d = c3  ? ((m10_q == 3'd5) ? 3'd0 : m10_q + 3'd1) : m10_q;

    assign do_clear = (state_q == PAUSE) && cmd_clr;
    assign lap_take = (state_q == RUN) && cmd_lap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            s1_q      <= '0;
            s10_q     <= '0;
            m1_q      <= '0;
            m10_q     <= '0;
            l_s1_q    <= '0;
            l_s10_q   <= '0;
            l_m1_q    <= '0;
            l_m10_q   <= '0;
            min_evt_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE:    if (cmd_ss) state_q <= RUN;
                RUN:     if (cmd_ss) state_q <= PAUSE;
                         else if (cmd_lap) state_q <= LAP;
                LAP:     if (cmd_ss) state_q <= PAUSE;
                         else if (cmd_lap) state_q <= RUN;
                PAUSE:   if (cmd_clr) state_q <= IDLE;
                         else if (cmd_ss) state_q <= RUN;
                default: state_q <= IDLE;
            endcase

            if (do_clear) begin
                s1_q    <= '0;
                s10_q   <= '0;
                m1_q    <= '0;
                m10_q   <= '0;
                l_s1_q  <= '0;
                l_s10_q <= '0;
                l_m1_q  <= '0;
                l_m10_q <= '0;
            end else begin
                s1_q  <= s1_d;
                s10_q <= s10_d;
                m1_q  <= m1_d;
                m10_q <= m10_d;
                // The latch captures the pre-increment value while the live chain keeps counting.
                if (lap_take) begin
                    l_s1_q  <= s1_q;
                    l_s10_q <= s10_q;
                    l_m1_q  <= m1_q;
                    l_m10_q <= m10_q;
                end
            end

            min_evt_q <= c2;
        end
    end

`ifdef STOPWATCH_OVFL_EN
    logic ovfl_q;
    logic ovfl_set;

    // Wrap mode flags the rollover; hold mode flags the first arrival at 59:59.
    assign ovfl_set = SAT_MODE ? (en0 && (s1_d == 4'd9) && (s10_d == 3'd5) &&
                                  (m1_d == 4'd9) && (m10_d == 3'd5))
                               : c4;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ovfl_q <= 1'b0;
        else if (do_clear)
            ovfl_q <= 1'b0;
        else if (ovfl_set)
            ovfl_q <= 1'b1;
    end

    assign sw.ovfl = ovfl_q;
`else
    logic unused_c4;
    assign unused_c4 = c4;
`endif

    assign sw.disp_s1  = (state_q == LAP) ? l_s1_q  : s1_q;
    assign sw.disp_s10 = (state_q == LAP) ? l_s10_q : s10_q;
    assign sw.disp_m1  = (state_q == LAP) ? l_m1_q  : m1_q;
    assign sw.disp_m10 = (state_q == LAP) ? l_m10_q : m10_q;
    assign sw.running  = counting;
    assign sw.lap_hold = (state_q == LAP);
    assign sw.min_evt  = min_evt_q;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - scoreboard bench for stopwatch_ctrl; STOPWATCH_OVFL_EN also checks ovfl
module tb_stopwatch_ctrl;
    localparam bit SAT_MODE = 1'b0;

    logic clk;
    logic rst_n;
    stopwatch_ctrl_if sw();

    stopwatch_ctrl #(.SAT_MODE(SAT_MODE)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sw    (sw)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [16:0] vec;
        int         evt;
        bit         ovfl;
    } exp_t;

    exp_t exp_q[$];
    bit   smp;
    int   evt_cnt;
    int   n_cmp;
    int   n_bad;

    // Monitor: counts min_evt cycles and checks queued expectations whenever a sample is requested.
    always @(negedge clk) begin
        exp_t e;
        logic [16:0] act;
        if (sw.min_evt) evt_cnt++;
        if (smp) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL scoreboard_underflow: sample with no expectation queued");
            end else begin
                e = exp_q.pop_front();
                act = {sw.disp_m10, sw.disp_m1, sw.disp_s10, sw.disp_s1,
                       sw.running, sw.lap_hold, sw.min_evt};
                if (act !== e.vec) begin
                    n_bad++;
                    $display("FAIL %s: got m10m1s10s1/run/lap/evt=%h required %h", e.name, act, e.vec);
                end
                n_cmp++;
                if (evt_cnt != e.evt) begin
                    n_bad++;
                    $display("FAIL %s_evtcnt: got %0d required %0d", e.name, evt_cnt, e.evt);
                end
`ifdef STOPWATCH_OVFL_EN
                n_cmp++;
                if (sw.ovfl !== e.ovfl) begin
                    n_bad++;
                    $display("FAIL %s_ovfl: got %b required %b", e.name, sw.ovfl, e.ovfl);
                end
`endif
            end
        end
    end

    task automatic check(input string nm, input logic [2:0] m10, input logic [3:0] m1,
                         input logic [2:0] s10, input logic [3:0] s1,
                         input bit run, input bit lh, input bit me, input int ec, input bit ov);
        exp_t e;
        e.name = nm;
        e.vec  = {m10, m1, s10, s1, run, lh, me};
        e.evt  = ec;
        e.ovfl = ov;
        exp_q.push_back(e);
        smp = 1'b1;
        @(negedge clk);
        #1 smp = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input bit t, input bit ss, input bit lp, input bit cl);
        sw.tick = t; sw.start_stop = ss; sw.lap = lp; sw.clr = cl;
        @(posedge clk);
        #1;
        sw.tick = 1'b0; sw.start_stop = 1'b0; sw.lap = 1'b0; sw.clr = 1'b0;
    endtask

    task automatic ticks(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            pulse(1'b1, 1'b0, 1'b0, 1'b0);
            repeat (gap - 1) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int ec;
        smp = 1'b0; evt_cnt = 0; n_cmp = 0; n_bad = 0;
        sw.tick = 1'b0; sw.start_stop = 1'b0; sw.lap = 1'b0; sw.clr = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        check("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Test 1
        pulse(0, 1, 0, 0);
        check("start", 0, 0, 0, 0, 1, 0, 0, 0, 0);
        ticks(10, 3);
        check("ten_ticks", 0, 0, 1, 0, 1, 0, 0, 0, 0);

        // Test 2
        ticks(49, 2);
        check("at_0059", 0, 0, 5, 9, 1, 0, 0, 0, 0);
        pulse(1, 0, 0, 0);
        check("min_wrap", 0, 1, 0, 0, 1, 0, 1, 1, 0);
        check("min_evt_gone", 0, 1, 0, 0, 1, 0, 0, 1, 0);

        // Test 3
        pulse(0, 1, 0, 0);
        pulse(0, 0, 0, 1);
        check("clr_idle", 0, 0, 0, 0, 0, 0, 0, 1, 0);
        pulse(0, 1, 0, 0);
        ticks(5, 2);
        check("at_0005", 0, 0, 0, 5, 1, 0, 0, 1, 0);
        pulse(1, 0, 1, 0);
        check("lap_freeze", 0, 0, 0, 5, 1, 1, 0, 1, 0);
        ticks(3, 2);
        check("lap_frozen", 0, 0, 0, 5, 1, 1, 0, 1, 0);
        pulse(0, 0, 1, 0);
        check("lap_release", 0, 0, 0, 9, 1, 0, 0, 1, 0);
        pulse(0, 0, 1, 1);
        check("clr_drops_lap", 0, 0, 0, 9, 1, 0, 0, 1, 0);

        // Test 4
        pulse(0, 1, 0, 0);
        pulse(0, 0, 0, 1);
        pulse(1, 1, 0, 0);
        check("idle_start_tick", 0, 0, 0, 0, 1, 0, 0, 1, 0);
        ticks(3, 2);
        check("at_0003", 0, 0, 0, 3, 1, 0, 0, 1, 0);
        pulse(1, 1, 0, 0);
        check("pause_tick_counts", 0, 0, 0, 4, 0, 0, 0, 1, 0);
        pulse(1, 0, 0, 0);
        pulse(0, 0, 1, 0);
        check("pause_holds", 0, 0, 0, 4, 0, 0, 0, 1, 0);
        pulse(0, 1, 0, 1);
        check("clr_beats_ss", 0, 0, 0, 0, 0, 0, 0, 1, 0);

        // Test 5
        pulse(0, 1, 0, 0);
        ticks(3599, 1);
        check("at_5959", 5, 9, 5, 9, 1, 0, 0, 60, SAT_MODE);
        pulse(1, 0, 0, 0);
        ec = SAT_MODE ? 60 : 61;
        if (SAT_MODE) check("sat_hold", 5, 9, 5, 9, 1, 0, 0, ec, 1);
        else          check("wrap_0000", 0, 0, 0, 0, 1, 0, 1, ec, 1);
        if (SAT_MODE) check("sat_hold2", 5, 9, 5, 9, 1, 0, 0, ec, 1);
        else          check("wrap_after", 0, 0, 0, 0, 1, 0, 0, ec, 1);
        pulse(0, 1, 0, 0);
        pulse(0, 0, 0, 1);
        check("ovfl_cleared", 0, 0, 0, 0, 0, 0, 0, ec, 0);

        // Test 6
        pulse(0, 1, 0, 0);
        ticks(754, 1);
        ec = ec + 12;
        check("at_1234", 1, 2, 3, 4, 1, 0, 0, ec, 0);
        #2 rst_n = 1'b0;
        check("async_reset", 0, 0, 0, 0, 0, 0, 0, ec, 0);
        rst_n = 1'b1;
        pulse(1, 0, 0, 0);
        check("post_reset_tick", 0, 0, 0, 0, 0, 0, 0, ec, 0);

        @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: %0d left required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
